// File: rtl/ge_p3_tobytes.sv
// ge_p3_tobytes
// -------------
// Compresses an extended-coordinate point (X:Y:Z:T) to its 32-byte encoding:
// s = tobytes(Y/Z), with bit 255 replaced by isnegative(X/Z).
// 1/Z is computed as Z^(p-2), p = 2^255-19, by left-to-right square-and-multiply
// on an external shared field multiplier. Two further multiplies form X/Z and
// Y/Z, and a final cycle packs the bytes.
//
// Field elements use the 10x32-bit limb format. Limb k sits in bits
// [32k+31:32k] as a signed two's complement integer with weight
// 2^ceil(25.5*k), so the limb offsets are 0,26,51,77,102,128,153,179,204,230.
// Limbs do not have to be canonical; fe_tobytes reduces fully mod p.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   h_x, h_y, h_z, h_t  point coordinates (h_t unused)
//   valid               start request, sampled in IDLE only
//   s, error, done      result bytes, zero-Z flag, one-cycle completion pulse
//   mul_op_a, mul_op_b  multiplier operands
//   mul_valid           multiplier request pulse
//   mul_res, mul_done   multiplier result and its strobe
//   dbg_state           current FSM state
//
// Multiplier handshake: mul_valid is high for exactly one cycle (the issue
// cycle) per request. mul_op_a/mul_op_b are set in that cycle and stay
// unchanged until mul_done is sampled. mul_done is accepted only in a wait
// cycle of a multiply state, i.e. never in the issue cycle itself, and the
// next request is issued in the cycle after the accepted mul_done.
//
// Configuration macro: GE_TOBYTES_ZERO_CHECK_EN. When defined, a Z that
// reduces to 0 is detected at the start request and reported with error=1
// two cycles after valid, without issuing any multiply. When undefined,
// error is always 0.

module ge_p3_tobytes (
  input  logic         clk,
  input  logic         rst,
  input  logic [319:0] h_x,
  input  logic [319:0] h_y,
  input  logic [319:0] h_z,
  input  logic [319:0] h_t,
  input  logic         valid,
  output logic [255:0] s,
  output logic         error,
  output logic         done,
  output logic [319:0] mul_op_a,
  output logic [319:0] mul_op_b,
  output logic         mul_valid,
  input  logic [319:0] mul_res,
  input  logic         mul_done,
  output logic [2:0]   dbg_state
);

  localparam logic signed [263:0] FE_P = (264'sd1 <<< 255) - 264'sd19;

  // Full reduction of a limb vector to its canonical 255-bit value.
  function automatic logic [255:0] fe_tobytes(input logic [319:0] f);
    logic signed [263:0] acc;
    logic signed [263:0] t;
    logic signed [263:0] hi;
    logic signed [263:0] lo;
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      t   = {{232{f[32*k+31]}}, f[32*k +: 32]};
      acc = acc + (t <<< ((51 * k + 1) / 2));
    end
    // 2^255 == 19 (mod p): fold the high part back twice. After the second
    // fold the value lies in [-19, 2^255+18], so one correction finishes it.
    for (int n = 0; n < 2; n++) begin
      hi  = acc >>> 255;
      lo  = {9'd0, acc[254:0]};
      acc = lo + (hi <<< 4) + (hi <<< 1) + hi;
    end
    if (acc < 0) begin
      acc = acc + FE_P;
    end else if (acc >= FE_P) begin
      acc = acc - FE_P;
    end
    return acc[255:0];
  endfunction

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INV_SQ  = 3'd1,
    S_INV_MUL = 3'd2,
    S_MUL_X   = 3'd3,
    S_MUL_Y   = 3'd4,
    S_PACK    = 3'd5,
    S_ZERO    = 3'd6
  } state_t;

  state_t       r_state;
  logic [319:0] r_x;      // X, then X/Z after MUL_X
  logic [319:0] r_y;      // Y, then Y/Z after MUL_Y
  logic [319:0] r_z;
  logic [319:0] r_acc;    // running power of Z
  logic [7:0]   r_i;      // exponent bit index

  logic         w_accept;
  logic         w_ebit;
  logic [255:0] w_x_bytes;
  logic [255:0] w_y_bytes;
  logic         w_unused;

  assign dbg_state = r_state;

  // The issue cycle is the only cycle with mul_valid high, so a strobe in
  // that cycle is never taken.
  assign w_accept = mul_done & ~mul_valid;

  // p-2 = 2^255-21: bits 254..0 are all ones except bits 2 and 4.
  assign w_ebit = (r_i != 8'd2) && (r_i != 8'd4);

  assign w_x_bytes = fe_tobytes(r_x);
  assign w_y_bytes = fe_tobytes(r_y);

  // Canonical bytes always have bit 255 clear; only bit 0 of X matters.
  assign w_unused = ^{h_t, w_x_bytes[255:1], w_y_bytes[255]};

`ifdef GE_TOBYTES_ZERO_CHECK_EN
  logic [255:0] w_z_bytes;
  logic         w_z_zero;
  assign w_z_bytes = fe_tobytes(h_z);
  assign w_z_zero  = (w_z_bytes == 256'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_acc     <= '0;
      r_i       <= '0;
      s         <= '0;
      error     <= 1'b0;
      done      <= 1'b0;
      mul_valid <= 1'b0;
      mul_op_a  <= '0;
      mul_op_b  <= '0;
    end else begin
      done      <= 1'b0;
      mul_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_x   <= h_x;
            r_y   <= h_y;
            r_z   <= h_z;
            r_acc <= h_z;   // covers exponent bit 254
            r_i   <= 8'd253;
`ifdef GE_TOBYTES_ZERO_CHECK_EN
            if (w_z_zero) begin
              r_state <= S_ZERO;
            end else begin
              mul_valid <= 1'b1;
              mul_op_a  <= h_z;
              mul_op_b  <= h_z;
              r_state   <= S_INV_SQ;
            end
`else
            mul_valid <= 1'b1;
            mul_op_a  <= h_z;
            mul_op_b  <= h_z;
            r_state   <= S_INV_SQ;
`endif
          end
        end

        S_INV_SQ: begin
          if (w_accept) begin
            r_acc <= mul_res;
            mul_valid <= 1'b1;
            if (w_ebit) begin
              mul_op_a <= mul_res;
              mul_op_b <= r_z;
              r_state  <= S_INV_MUL;
            end else if (r_i == 8'd0) begin
              mul_op_a <= r_x;
              mul_op_b <= mul_res;
              r_state  <= S_MUL_X;
            end else begin
              r_i      <= r_i - 8'd1;
              mul_op_a <= mul_res;
              mul_op_b <= mul_res;
            end
          end
        end

        S_INV_MUL: begin
          if (w_accept) begin
            r_acc <= mul_res;
            mul_valid <= 1'b1;
            if (r_i == 8'd0) begin
              mul_op_a <= r_x;
              mul_op_b <= mul_res;
              r_state  <= S_MUL_X;
            end else begin
              r_i      <= r_i - 8'd1;
              mul_op_a <= mul_res;
              mul_op_b <= mul_res;
              r_state  <= S_INV_SQ;
            end
          end
        end

        S_MUL_X: begin
          if (w_accept) begin
            r_x       <= mul_res;
            mul_valid <= 1'b1;
            mul_op_a  <= r_y;
            mul_op_b  <= r_acc;
            r_state   <= S_MUL_Y;
          end
        end

        S_MUL_Y: begin
          if (w_accept) begin
            r_y     <= mul_res;
            r_state <= S_PACK;
          end
        end

        S_PACK: begin
          s       <= {w_x_bytes[0], w_y_bytes[254:0]};
          error   <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end

`ifdef GE_TOBYTES_ZERO_CHECK_EN
        S_ZERO: begin
          s       <= '0;
          error   <= 1'b1;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
`endif

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ge_p3_tobytes.sv
module tb_ge_p3_tobytes;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [319:0] h_x = '0, h_y = '0, h_z = '0, h_t = '0;
  logic         valid = 1'b0;
  logic [255:0] s;
  logic         error, done;
  logic [319:0] mul_op_a, mul_op_b;
  logic         mul_valid;
  logic [319:0] mul_res;
  logic         mul_done;
  logic [2:0]   dbg_state;

  ge_p3_tobytes dut (
    .clk(clk), .rst(rst),
    .h_x(h_x), .h_y(h_y), .h_z(h_z), .h_t(h_t),
    .valid(valid),
    .s(s), .error(error), .done(done),
    .mul_op_a(mul_op_a), .mul_op_b(mul_op_b), .mul_valid(mul_valid),
    .mul_res(mul_res), .mul_done(mul_done),
    .dbg_state(dbg_state)
  );

  // ---------------- constants ----------------
  localparam logic [255:0] P  = (256'd1 << 255) - 256'd19;
  localparam logic signed [263:0] PS = (264'sd1 <<< 255) - 264'sd19;
  localparam logic [255:0] BX = 256'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
  localparam logic [255:0] BY = {{31{8'h66}}, 8'h58};
  localparam logic [255:0] K  = 256'h0123456789abcdef0fedcba9876543211122334455667788a1b2c3d4e5f60718;
  // Base point encoding: byte0=0x58, bytes 1..31 = 0x66; BX is even.
  localparam logic [255:0] S_BASE = {{31{8'h66}}, 8'h58};
  localparam logic [255:0] S_NEG  = {8'he6, {30{8'h66}}, 8'h58};

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [256:0] exp_q[$];   // {error, s}
  int           lat_q[$];   // absolute cycle at which done is due

  task automatic check_eq(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- field model ----------------
  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] pr;
    pr = {256'd0, a} * {256'd0, b};
    pr = pr % {256'd0, P};
    return pr[255:0];
  endfunction

  function automatic logic [255:0] from_limbs(input logic [319:0] f);
    logic signed [263:0] acc;
    logic signed [263:0] t;
    logic signed [263:0] r;
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      t   = {{232{f[32*k+31]}}, f[32*k +: 32]};
      acc = acc + (t <<< ((51 * k + 1) / 2));
    end
    r = acc % PS;
    if (r < 0) r = r + PS;
    return r[255:0];
  endfunction

  function automatic logic [319:0] to_limbs(input logic [255:0] v);
    logic [319:0] l;
    logic [255:0] t;
    for (int k = 0; k < 10; k++) begin
      t = v >> ((51 * k + 1) / 2);
      if (k == 9)          l[32*k +: 32] = t[31:0];
      else if (k % 2 == 0) l[32*k +: 32] = t[31:0] & 32'h03ff_ffff;
      else                 l[32*k +: 32] = t[31:0] & 32'h01ff_ffff;
    end
    return l;
  endfunction

  // ---------------- multiplier model ----------------
  int           mul_lat = 1;
  int           n_mul = 0;
  int           run_idx = 0;
  logic         pend;
  int           cnt;
  logic [319:0] cap_a, cap_b;

  // Results alternate between canonical, value+p and a negative low limb.
  function automatic logic [319:0] encode(input logic [255:0] r, input int mode);
    logic [319:0] l;
    if (mode == 1) begin
      l = to_limbs(r + P);
    end else begin
      l = to_limbs(r);
      if (mode == 2) begin
        l[31:0]  = l[31:0] - 32'h0400_0000;
        l[63:32] = l[63:32] + 32'd1;
      end
    end
    return l;
  endfunction

  initial begin
    mul_done = 1'b0;
    mul_res  = '0;
    pend     = 1'b0;
    cnt      = 0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        check_eq("mul_op_a_stable", mul_op_a, cap_a);
        check_eq("mul_op_b_stable", mul_op_b, cap_b);
        check_eq("mul_valid_single", {319'd0, mul_valid}, 320'd0);
        cnt--;
        if (cnt == 0) begin
          mul_res  = encode(fmul(from_limbs(cap_a), from_limbs(cap_b)), (n_mul + run_idx) % 3);
          mul_done = 1'b1;
          pend     = 1'b0;
        end
      end else if (mul_valid) begin
        pend  = 1'b1;
        cnt   = mul_lat;
        cap_a = mul_op_a;
        cap_b = mul_op_b;
        n_mul++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [256:0] e;
    int           due;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 320'd1, 320'd0);
        end else begin
          e   = exp_q.pop_front();
          due = lat_q.pop_front();
          check_eq("s", {64'd0, s}, {64'd0, e[255:0]});
          check_eq("error", {319'd0, error}, {319'd0, e[256]});
          check_eq("done_cycle", 320'(cyc), 320'(due));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_vec(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                         input int lat, input logic [255:0] exp_s, input logic exp_err,
                         input int exp_lat, input int exp_muls, input int hold);
    int budget;
    mul_lat = lat;
    run_idx++;
    n_mul = 0;
    @(negedge clk);
    h_x = to_limbs(x);
    h_y = to_limbs(y);
    h_z = to_limbs(z);
    valid = 1'b1;
    exp_q.push_back({exp_err, exp_s});
    lat_q.push_back(cyc + exp_lat);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      // Inputs change while valid stays high; only the first sample counts.
      h_x = to_limbs(256'd7);
      h_y = to_limbs(256'd9);
      h_z = to_limbs(256'd3);
    end
    @(negedge clk);
    valid = 1'b0;
    budget = exp_lat + 50;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      check_eq("done_timeout", 320'd1, 320'd0);
      exp_q.delete();
      lat_q.delete();
    end
    check_eq("mul_count", 320'(n_mul), 320'(exp_muls));
    repeat (5) @(negedge clk);
  endtask

  task automatic reset_mid_run(input logic [255:0] prev_s);
    int   budget;
    logic found;
    mul_lat = 1;
    run_idx++;
    n_mul = 0;
    @(negedge clk);
    h_x = to_limbs(BX);
    h_y = to_limbs(BY);
    h_z = to_limbs(256'd1);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    budget = 1000;
    found = 1'b0;
    while (budget > 0 && !found) begin
      @(negedge clk);
      #1;
      if (n_mul >= 200) found = 1'b1;
      budget--;
    end
    check_eq("request_200_reached", {319'd0, found}, 320'd1);
    check_eq("s_held_mid_run", {64'd0, s}, {64'd0, prev_s});
    check_eq("mul_valid_at_200", {319'd0, mul_valid}, 320'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_s", {64'd0, s}, 320'd0);
    check_eq("rst_error", {319'd0, error}, 320'd0);
    check_eq("rst_done", {319'd0, done}, 320'd0);
    check_eq("rst_mul_valid", {319'd0, mul_valid}, 320'd0);
    check_eq("rst_mul_op_a", mul_op_a, 320'd0);
    check_eq("rst_mul_op_b", mul_op_b, 320'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] nbx;
    nbx = P - BX;

    repeat (3) @(negedge clk);
    check_eq("reset_s", {64'd0, s}, 320'd0);
    check_eq("reset_error", {319'd0, error}, 320'd0);
    check_eq("reset_done", {319'd0, done}, 320'd0);
    check_eq("reset_mul_valid", {319'd0, mul_valid}, 320'd0);
    check_eq("reset_mul_op_a", mul_op_a, 320'd0);
    check_eq("reset_mul_op_b", mul_op_b, 320'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // base point, Z=1
    run_vec(BX, BY, 256'd1, 1, S_BASE, 1'b0, 508 * 2 + 2, 508, 1);
    // scaled by 2
    run_vec(fmul(BX, 256'd2), fmul(BY, 256'd2), 256'd2, 3, S_BASE, 1'b0, 508 * 4 + 2, 508, 1);
    // negated X
    run_vec(nbx, BY, 256'd1, 1, S_NEG, 1'b0, 508 * 2 + 2, 508, 1);
    // negated X, scaled by a large constant
    run_vec(fmul(nbx, K), fmul(BY, K), K, 2, S_NEG, 1'b0, 508 * 3 + 2, 508, 1);
    // long multiplier latency
    run_vec(BX, BY, 256'd1, 7, S_BASE, 1'b0, 508 * 8 + 2, 508, 1);
    // valid held for 100 cycles, then a fresh request with new inputs
    run_vec(BX, BY, 256'd1, 2, S_BASE, 1'b0, 508 * 3 + 2, 508, 100);
    run_vec(nbx, BY, 256'd1, 1, S_NEG, 1'b0, 508 * 2 + 2, 508, 1);
    // abort at request 200, then a complete run
    reset_mid_run(S_NEG);
    run_vec(BX, BY, 256'd1, 1, S_BASE, 1'b0, 508 * 2 + 2, 508, 1);
    // Z = p, which reduces to 0
`ifdef GE_TOBYTES_ZERO_CHECK_EN
    run_vec(BX, BY, P, 1, 256'd0, 1'b1, 2, 0, 1);
`else
    run_vec(BX, BY, P, 1, 256'd0, 1'b0, 508 * 2 + 2, 508, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
